// File: rtl/masked_match_pipe_if.sv
// masked_match_pipe_if
//   Bundles the data/qualifier inputs and the result outputs of
//   masked_match_pipe. The DUT attaches through the slave modport and the
//   producer/consumer side through the master modport.
//
//   Signals:
//     sclr        synchronous clear of valids, hit counter and sticky flag
//     din_valid   qualifies din
//     din         data word under test            [WIDTH]
//     match_valid qualifies the result fields
//     match_vec   bit i = word matched pattern i  [NUM_PAT]
//     any_match   OR of match_vec
//     first_idx   lowest matching pattern index   [IDX_WIDTH]
//     hit_count   saturating count of hit results [CNT_WIDTH]
//     hit_seen    sticky "a hit result was seen"
interface masked_match_pipe_if #(
    parameter int WIDTH     = 8,
    parameter int NUM_PAT   = 4,
    parameter int IDX_WIDTH = 2,
    parameter int CNT_WIDTH = 16
);
    logic                 sclr;
    logic                 din_valid;
    logic [WIDTH-1:0]     din;
    logic                 match_valid;
    logic [NUM_PAT-1:0]   match_vec;
    logic                 any_match;
    logic [IDX_WIDTH-1:0] first_idx;
    logic [CNT_WIDTH-1:0] hit_count;
    logic                 hit_seen;

    modport master (
        output sclr, din_valid, din,
        input  match_valid, match_vec, any_match, first_idx, hit_count, hit_seen
    );

    modport slave (
        input  sclr, din_valid, din,
        output match_valid, match_vec, any_match, first_idx, hit_count, hit_seen
    );
endinterface

// File: rtl/masked_match_pipe.sv
// masked_match_pipe
//   Two-stage registered multi-pattern comparator. Each valid input word is
//   compared against NUM_PAT constant patterns, each with its own per-bit
//   compare mask (1 = compare, 0 = don't care). Results appear exactly two
//   cycles after the word is sampled, one word per cycle, no backpressure.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset, clears every register
//     bus    masked_match_pipe_if.slave (sclr, din_valid, din in;
//            match_valid, match_vec, any_match, first_idx, hit_count,
//            hit_seen out)
//
//   Result fields hold their last value while match_valid is low. The hit
//   counter saturates at all-ones; hit_seen is sticky until sclr or reset.
module masked_match_pipe #(
    parameter int                           WIDTH     = 8,
    parameter int                           NUM_PAT   = 4,
    parameter int                           IDX_WIDTH = 2,
    parameter logic [NUM_PAT*WIDTH-1:0]     PATTERNS  = 32'h0F_A0_0C_45,
    parameter logic [NUM_PAT*WIDTH-1:0]     MASKS     = 32'hF0_FF_FF_FF,
    parameter int                           CNT_WIDTH = 16
) (
    input logic                clk,
    input logic                rst_n,
    masked_match_pipe_if.slave bus
);

    if ((2 ** IDX_WIDTH) < NUM_PAT) begin : g_bad_idx_width
        $error("IDX_WIDTH too narrow for NUM_PAT");
    end

    // ------------------------------------------------------------------
    // Stage 1: masked compare against every pattern
    // ------------------------------------------------------------------
    logic [NUM_PAT-1:0] eq;

    // NOTE: every always_comb output gets a default before any conditional
    // logic so no path can leave it unassigned and infer a latch.
    always_comb begin
        eq = '0;
        for (int i = 0; i < NUM_PAT; i++) begin
            eq[i] = ((bus.din ^ PATTERNS[i*WIDTH +: WIDTH]) & MASKS[i*WIDTH +: WIDTH]) == '0;
        end
    end

    logic               s1_valid;
    logic [NUM_PAT-1:0] s1_eq;

    // A word presented together with sclr is dropped, so the load enable
    // and the valid both exclude it.
    logic s1_load;
    assign s1_load = bus.din_valid && !bus.sclr;

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    // NOTE: data registers are reset too, because all outputs must read 0
    // while rst_n is low; sclr, by contrast, leaves data registers alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_eq    <= '0;
        end else begin
            s1_valid <= s1_load;
            if (s1_load) begin
                s1_eq <= eq;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: reduce the hit vector, lowest index wins
    // ------------------------------------------------------------------
    logic [IDX_WIDTH-1:0] idx_next;

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx_next = '0;
        for (int i = NUM_PAT - 1; i >= 0; i--) begin
            if (s1_eq[i]) begin
                idx_next = IDX_WIDTH'(i);
            end
        end
    end

    logic                 match_valid_q;
    logic [NUM_PAT-1:0]   match_vec_q;
    logic                 any_match_q;
    logic [IDX_WIDTH-1:0] first_idx_q;

    // An in-flight stage-1 word is discarded by sclr as well.
    logic s2_load;
    assign s2_load = s1_valid && !bus.sclr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_valid_q <= 1'b0;
            match_vec_q   <= '0;
            any_match_q   <= 1'b0;
            first_idx_q   <= '0;
        end else begin
            match_valid_q <= s2_load;
            if (s2_load) begin
                match_vec_q <= s1_eq;
                any_match_q <= |s1_eq;
                first_idx_q <= idx_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Hit statistics: counted one edge after a hit result is presented
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] hit_count_q;
    logic                 hit_seen_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_q <= '0;
            hit_seen_q  <= 1'b0;
        end else if (bus.sclr) begin
            hit_count_q <= '0;
            hit_seen_q  <= 1'b0;
        end else if (match_valid_q && any_match_q) begin
            hit_seen_q <= 1'b1;
            if (hit_count_q != '1) begin
                hit_count_q <= hit_count_q + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.match_valid = match_valid_q;
    assign bus.match_vec   = match_vec_q;
    assign bus.any_match   = any_match_q;
    assign bus.first_idx   = first_idx_q;
    assign bus.hit_count   = hit_count_q;
    assign bus.hit_seen    = hit_seen_q;

endmodule

// File: tb/tb_masked_match_pipe.sv
// tb_masked_match_pipe
//   Drives two instances sharing the same stimulus: dut_a with the default
//   16-bit hit counter and dut_b with a 3-bit counter for saturation.
//   Directed scenarios use hand-derived expected values; the random scenario
//   uses a word-level reference model (delay line + pattern rule).
module tb_masked_match_pipe;

    localparam int WIDTH     = 8;
    localparam int NUM_PAT   = 4;
    localparam int IDX_WIDTH = 2;
    localparam int CNT_A     = 16;
    localparam int CNT_B     = 3;
    localparam logic [31:0] PATS  = 32'h0F_A0_0C_45;
    localparam logic [31:0] MSKS  = 32'hF0_FF_FF_FF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclr = 1'b0;
    logic       din_valid = 1'b0;
    logic [7:0] din = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    masked_match_pipe_if #(.WIDTH(WIDTH), .NUM_PAT(NUM_PAT), .IDX_WIDTH(IDX_WIDTH), .CNT_WIDTH(CNT_A)) bus_a ();
    masked_match_pipe_if #(.WIDTH(WIDTH), .NUM_PAT(NUM_PAT), .IDX_WIDTH(IDX_WIDTH), .CNT_WIDTH(CNT_B)) bus_b ();

    assign bus_a.sclr = sclr;
    assign bus_a.din_valid = din_valid;
    assign bus_a.din = din;
    assign bus_b.sclr = sclr;
    assign bus_b.din_valid = din_valid;
    assign bus_b.din = din;

    masked_match_pipe #(.WIDTH(WIDTH), .NUM_PAT(NUM_PAT), .IDX_WIDTH(IDX_WIDTH),
                        .PATTERNS(PATS), .MASKS(MSKS), .CNT_WIDTH(CNT_A))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

    masked_match_pipe #(.WIDTH(WIDTH), .NUM_PAT(NUM_PAT), .IDX_WIDTH(IDX_WIDTH),
                        .PATTERNS(PATS), .MASKS(MSKS), .CNT_WIDTH(CNT_B))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    // {match_valid, match_vec, any_match, first_idx}
    wire [7:0] obs_a = {bus_a.match_valid, bus_a.match_vec, bus_a.any_match, bus_a.first_idx};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        din_valid = 1'b0;
        sclr = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- reference rule ----------------
    function automatic logic [3:0] ref_vec(input logic [7:0] d);
        logic [31:0] p;
        logic [31:0] m;
        logic [3:0]  v;
        p = PATS;
        m = MSKS;
        v = '0;
        for (int j = 0; j < NUM_PAT; j++) begin
            v[j] = ((d ^ p[j*8 +: 8]) & m[j*8 +: 8]) == 8'h00;
        end
        return v;
    endfunction

    function automatic logic [1:0] ref_idx(input logic [3:0] v);
        for (int j = 0; j < NUM_PAT; j++) begin
            if (v[j]) return 2'(j);
        end
        return 2'd0;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        din_valid = 1'b1;
        din = 8'h45;
        repeat (5) tick();
        n_cmp++;
        if ({obs_a, bus_a.hit_count, bus_a.hit_seen, bus_b.hit_count, bus_b.hit_seen} !== '0) begin
            n_bad++;
            $display("FAIL reset_hold: obs=%h cnt=%0d seen=%b, expected all zero",
                     obs_a, bus_a.hit_count, bus_a.hit_seen);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (bus_a.match_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_lat1: match_valid=%b, expected 0", bus_a.match_valid);
        end
        din_valid = 1'b0;
        tick();
        n_cmp++;
        if (obs_a !== {1'b1, 4'b0001, 1'b1, 2'd0}) begin
            n_bad++;
            $display("FAIL reset_lat2: obs=%b expected %b", obs_a, {1'b1, 4'b0001, 1'b1, 2'd0});
        end
        tick();
        n_cmp++;
        if ({bus_a.match_valid, bus_a.hit_count, bus_a.hit_seen} !== {1'b0, 16'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_first_hit: mv=%b cnt=%0d seen=%b, expected 0/1/1",
                     bus_a.match_valid, bus_a.hit_count, bus_a.hit_seen);
        end
        // Reset in the middle of a word's flight: nothing emerges afterwards.
        din_valid = 1'b1;
        din = 8'h45;
        tick();
        din_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({obs_a, bus_a.hit_count, bus_a.hit_seen} !== '0) begin
            n_bad++;
            $display("FAIL reset_async: obs=%h cnt=%0d seen=%b, expected all zero",
                     obs_a, bus_a.hit_count, bus_a.hit_seen);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (bus_a.match_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_inflight_lost[%0d]: match_valid=%b expected 0", i, bus_a.match_valid);
            end
        end
    endtask

    task automatic test_multi_hit();
        logic [7:0] words [4] = '{8'h45, 8'h0C, 8'hA0, 8'h77};
        logic [7:0] expv  [4] = '{{1'b1, 4'b0001, 1'b1, 2'd0}, {1'b1, 4'b1010, 1'b1, 2'd1},
                                  {1'b1, 4'b0100, 1'b1, 2'd2}, {1'b1, 4'b0000, 1'b0, 2'd0}};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            din_valid = (i < 4);
            din = (i < 4) ? words[i] : 8'($urandom);
            tick();
            n_cmp++;
            if (i == 0) begin
                if (bus_a.match_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL multi_lat: match_valid=%b expected 0", bus_a.match_valid);
                end
            end else if (i <= 4) begin
                if (obs_a !== expv[i-1]) begin
                    n_bad++;
                    $display("FAIL multi_word%0d: obs=%b expected %b", i - 1, obs_a, expv[i-1]);
                end
            end else begin
                if (obs_a !== {1'b0, 4'b0000, 1'b0, 2'd0}) begin
                    n_bad++;
                    $display("FAIL multi_idle: obs=%b expected 00000000", obs_a);
                end
            end
        end
        n_cmp++;
        if ({bus_a.hit_count, bus_a.hit_seen} !== {16'd3, 1'b1}) begin
            n_bad++;
            $display("FAIL multi_count: cnt=%0d seen=%b expected 3/1", bus_a.hit_count, bus_a.hit_seen);
        end
    endtask

    task automatic test_mask();
        logic [7:0] words [2] = '{8'h0F, 8'h1F};
        logic [7:0] expv  [4] = '{{1'b0, 4'b0000, 1'b0, 2'd0}, {1'b1, 4'b1000, 1'b1, 2'd3},
                                  {1'b1, 4'b0000, 1'b0, 2'd0}, {1'b0, 4'b0000, 1'b0, 2'd0}};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            din_valid = (i < 2);
            din = (i < 2) ? words[i] : 8'($urandom);
            tick();
            n_cmp++;
            if (obs_a !== expv[i]) begin
                n_bad++;
                $display("FAIL mask_step%0d: obs=%b expected %b", i, obs_a, expv[i]);
            end
        end
    endtask

    task automatic test_gaps();
        logic       vld  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] word [7] = '{8'h45, 8'h00, 8'h00, 8'h00, 8'hA0, 8'h00, 8'h00};
        logic [7:0] expv [7] = '{{1'b0, 4'b0000, 1'b0, 2'd0}, {1'b1, 4'b0001, 1'b1, 2'd0},
                                 {1'b0, 4'b0001, 1'b1, 2'd0}, {1'b0, 4'b0001, 1'b1, 2'd0},
                                 {1'b0, 4'b0001, 1'b1, 2'd0}, {1'b1, 4'b0100, 1'b1, 2'd2},
                                 {1'b0, 4'b0100, 1'b1, 2'd2}};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            din_valid = vld[i];
            din = vld[i] ? word[i] : 8'($urandom);
            tick();
            n_cmp++;
            if (obs_a !== expv[i]) begin
                n_bad++;
                $display("FAIL gap_step%0d: obs=%b expected %b", i, obs_a, expv[i]);
            end
        end
    endtask

    task automatic test_saturation_sclr();
        do_reset();
        din_valid = 1'b1;
        din = 8'h45;
        // 12 edges: results on edges 2..12, counted on edges 3..12 -> 10 hits.
        repeat (12) tick();
        n_cmp++;
        if ({bus_a.hit_count, bus_b.hit_count, bus_b.hit_seen} !== {16'd10, 3'd7, 1'b1}) begin
            n_bad++;
            $display("FAIL sat_count: cnt_a=%0d cnt_b=%0d seen_b=%b expected 10/7/1",
                     bus_a.hit_count, bus_b.hit_count, bus_b.hit_seen);
        end
        // match_valid=1 and any_match=1 now, so sclr competes with an increment.
        sclr = 1'b1;
        tick();
        n_cmp++;
        if ({bus_a.match_valid, bus_a.hit_count, bus_a.hit_seen,
             bus_b.match_valid, bus_b.hit_count, bus_b.hit_seen} !== '0) begin
            n_bad++;
            $display("FAIL sclr_clear: mv=%b cnt_a=%0d seen_a=%b cnt_b=%0d seen_b=%b expected all 0",
                     bus_a.match_valid, bus_a.hit_count, bus_a.hit_seen, bus_b.hit_count, bus_b.hit_seen);
        end
        sclr = 1'b0;
        din_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({bus_a.match_valid, bus_a.hit_count, bus_a.hit_seen} !== '0) begin
                n_bad++;
                $display("FAIL sclr_flush%0d: mv=%b cnt=%0d seen=%b expected 0/0/0",
                         i, bus_a.match_valid, bus_a.hit_count, bus_a.hit_seen);
            end
        end
    endtask

    typedef struct packed {
        logic       v;
        logic [7:0] d;
    } word_t;

    task automatic test_random();
        word_t      pipe [$];
        word_t      w;
        logic       e_mv = 1'b0;
        logic [3:0] e_vec = '0;
        logic       e_any = 1'b0;
        logic [1:0] e_idx = '0;
        int         e_cnt_a = 0;
        int         e_cnt_b = 0;
        logic       e_seen = 1'b0;
        logic [31:0] p = PATS;
        logic [31:0] m = MSKS;
        int         j;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            din_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0) begin
                j = $urandom_range(0, NUM_PAT - 1);
                din = p[j*8 +: 8] ^ (8'($urandom) & ~m[j*8 +: 8]);
                if ($urandom_range(0, 3) == 0) din = din ^ (8'd1 << $urandom_range(0, 7));
            end else begin
                din = 8'($urandom);
            end
            // Model of one clock edge.
            if (e_mv && e_any) begin
                e_seen = 1'b1;
                if (e_cnt_a < 65535) e_cnt_a++;
                if (e_cnt_b < 7) e_cnt_b++;
            end
            pipe.push_back('{v: din_valid, d: din});
            e_mv = 1'b0;
            if (pipe.size() == 2) begin
                w = pipe.pop_front();
                e_mv = w.v;
                if (w.v) begin
                    e_vec = ref_vec(w.d);
                    e_any = |e_vec;
                    e_idx = ref_idx(e_vec);
                end
            end
            tick();
            n_cmp++;
            if (obs_a !== {e_mv, e_vec, e_any, e_idx}) begin
                n_bad++;
                $display("FAIL rand_result@%0d: obs=%b expected %b", c, obs_a, {e_mv, e_vec, e_any, e_idx});
            end
            n_cmp++;
            if ({bus_a.hit_count, bus_a.hit_seen, bus_b.hit_count, bus_b.hit_seen} !==
                {16'(e_cnt_a), e_seen, 3'(e_cnt_b), e_seen}) begin
                n_bad++;
                $display("FAIL rand_stats@%0d: cnt_a=%0d cnt_b=%0d seen=%b expected %0d/%0d/%b",
                         c, bus_a.hit_count, bus_b.hit_count, bus_a.hit_seen, e_cnt_a, e_cnt_b, e_seen);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        test_reset();
        test_multi_hit();
        test_mask();
        test_gaps();
        test_saturation_sclr();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
